alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the basic 2-operand ALU used by the ALU VIP.
- Widens the opcode space to 8 operations and adds valid/ready backpressure on both sides.
- Fixed 2-cycle latency; exposes a zero flag and an accepted-result counter.
- Sits between a stimulus/producer and a consumer that may stall.

---
 rtl/alu_pipe.sv | 110 +++++++++++
 tb/tb_alu_pipe.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined 8-operation ALU with valid/ready handshakes on both sides.
// It also provides a zero flag qualified by valid_o and a wrapping count of delivered results.
module alu_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   data_i_1,
  input  logic [DATA_WIDTH-1:0]   data_i_2,
  input  logic [SEL_WIDTH-1:0]    sel_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [2*DATA_WIDTH-1:0] data_o,
  output logic                    zero_o,
  output logic [CNT_WIDTH-1:0]    res_cnt_o
);

  localparam int RW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_MAX = 3'd7
  } op_e;

  logic                  s1_valid;
  op_e                   s1_op;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic                  s1_load;
  logic                  s2_load;
  logic [RW-1:0]         a_ext;
  logic [RW-1:0]         b_ext;
  logic [RW-1:0]         result;

  // S2 frees up whenever it is empty or its result is leaving this cycle.
  // S1 can then advance into it, so ready_o depends combinationally on ready_i.
  assign s2_load = !valid_o || ready_i;
  assign s1_load = !s1_valid || s2_load;
  assign ready_o = s1_load;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= valid_i;
    end
  end

  // NOTE: operand registers have no reset; s1_valid alone decides whether they mean anything
  always_ff @(posedge clk) begin
    if (valid_i && s1_load) begin
      s1_op <= op_e'(sel_i[2:0]);
      s1_a  <= data_i_1;
      s1_b  <= data_i_2;
    end
  end

  assign a_ext = {{DATA_WIDTH{1'b0}}, s1_a};
  assign b_ext = {{DATA_WIDTH{1'b0}}, s1_b};

  always_comb begin
    // NOTE: default assigned first so every path drives result and no latch is inferred
    result = '0;
    case (s1_op)
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;  // wraps in 2W, i.e. sign-extended difference
      OP_MUL:  result = a_ext * b_ext;
      OP_AND:  result = a_ext & b_ext;
      OP_OR:   result = a_ext | b_ext;
      OP_XOR:  result = a_ext ^ b_ext;
      OP_SHL:  result = a_ext << s1_b;  // amounts >= 2W naturally yield zero
      OP_MAX:  result = (s1_a > s1_b) ? a_ext : b_ext;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      zero_o  <= 1'b0;
    end else if (s2_load) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        data_o <= result;
        zero_o <= (result == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt_o <= '0;
    end else if (valid_o && ready_i) begin
      res_cnt_o <= res_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomised checks for alu_pipe: opcodes, latency, throughput,
// backpressure, counter wrap (4-bit instance) and reset discarding in-flight work.
module tb_alu_pipe;

  localparam int W  = 8;
  localparam int SW = 3;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_i = 1'b1;
  logic [W-1:0]    data_i_1 = '0;
  logic [W-1:0]    data_i_2 = '0;
  logic [SW-1:0]   sel_i = '0;
  logic            ready_o, valid_o, zero_o;
  logic [2*W-1:0]  data_o;
  logic [CW-1:0]   res_cnt_o;
  logic            ready_o4, valid_o4, zero_o4;
  logic [2*W-1:0]  data_o4;
  logic [3:0]      res_cnt_o4;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.DATA_WIDTH(W), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i_1(data_i_1), .data_i_2(data_i_2), .sel_i(sel_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .zero_o(zero_o), .res_cnt_o(res_cnt_o)
  );

  alu_pipe #(.DATA_WIDTH(W), .SEL_WIDTH(SW), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o4),
    .data_i_1(data_i_1), .data_i_2(data_i_2), .sel_i(sel_i),
    .valid_o(valid_o4), .ready_i(ready_i), .data_o(data_o4),
    .zero_o(zero_o4), .res_cnt_o(res_cnt_o4)
  );

  always #5 clk = ~clk;

  // Reference model, written from the operation definitions.
  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, r;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    case (op)
      3'd0: r = ea + eb;
      3'd1: r = ea - eb;
      3'd2: r = ea * eb;
      3'd3: r = ea & eb;
      3'd4: r = ea | eb;
      3'd5: r = ea ^ eb;
      3'd6: begin
        r = ea;
        for (int i = 0; i < int'(b); i++) r = {r[2*W-2:0], 1'b0};
      end
      default: r = (a > b) ? ea : eb;
    endcase
    return r;
  endfunction

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  logic [2*W-1:0] exp_q[$];
  logic           mon_en = 1'b0;
  int             xfers = 0;
  int             run_len = 0;
  int             max_run = 0;
  logic           held = 1'b0;
  logic [2*W-1:0] held_data;
  logic           held_zero;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic [2*W-1:0] exp_v;
      if (held) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== held_data || zero_o !== held_zero) begin
          errors++;
          $display("FAIL stall_hold got v=%b d=%h z=%b exp v=1 d=%h z=%b", valid_o, data_o, zero_o, held_data, held_zero);
        end
      end
      held      = valid_o && !ready_i;
      held_data = data_o;
      held_zero = zero_o;
      run_len   = valid_o ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (valid_o && ready_i) begin
        xfers++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got %h exp none", data_o);
        end else begin
          exp_v = exp_q.pop_front();
          if (data_o !== exp_v || zero_o !== (exp_v == '0)) begin
            errors++;
            $display("FAIL sb_result got %h z=%b exp %h z=%b", data_o, zero_o, exp_v, (exp_v == '0));
          end
        end
      end
      if (valid_i && ready_o) exp_q.push_back(model(sel_i[2:0], data_i_1, data_i_2));
    end else begin
      held = 1'b0;
    end
  end

  task automatic do_reset();
    mon_en  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    xfers   = 0;
    run_len = 0;
    max_run = 0;
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the edge of acceptance.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int budget = 0;
    valid_i  = 1'b1;
    sel_i    = op;
    data_i_1 = a;
    data_i_2 = b;
    @(negedge clk);
    while (!ready_o && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!ready_o) begin
      checks++; errors++;
      $display("FAIL send_timeout got ready_o=0 exp 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int budget = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain got pending=%0d valid_o=%b exp 0 0", exp_q.size(), valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (valid_o !== 1'b0 || data_o !== '0 || zero_o !== 1'b0 || res_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h z=%b c=%0d exp 0 0 0 0", valid_o, data_o, zero_o, res_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready_o=%b valid_o=%b exp 1 0", ready_o, valid_o);
    end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    logic           z;
  } vec_t;

  task automatic test_opcodes();
    vec_t vecs [10];
    vecs = '{
      '{3'd0, 8'hFF, 8'h01, 16'h0100, 1'b0},
      '{3'd1, 8'h03, 8'h05, 16'hFFFE, 1'b0},
      '{3'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0},
      '{3'd3, 8'hF0, 8'h3C, 16'h0030, 1'b0},
      '{3'd4, 8'hF0, 8'h3C, 16'h00FC, 1'b0},
      '{3'd5, 8'hF0, 8'h3C, 16'h00CC, 1'b0},
      '{3'd6, 8'h81, 8'h04, 16'h0810, 1'b0},
      '{3'd6, 8'h01, 8'h10, 16'h0000, 1'b1},
      '{3'd7, 8'h7F, 8'h80, 16'h0080, 1'b0},
      '{3'd6, 8'h01, 8'h0F, 16'h8000, 1'b0}
    };
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid_i  = 1'b1;
      sel_i    = vecs[i].op;
      data_i_1 = vecs[i].a;
      data_i_2 = vecs[i].b;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_early got valid_o=%b exp 0", i, valid_o);
      end
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || data_o !== vecs[i].exp || zero_o !== vecs[i].z) begin
        errors++;
        $display("FAIL op%0d_result got v=%b d=%h z=%b exp v=1 d=%h z=%b", i, valid_o, data_o, zero_o, vecs[i].exp, vecs[i].z);
      end
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_single got valid_o=%b exp 0", i, valid_o);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (res_cnt_o !== 16'd10 || res_cnt_o4 !== 4'd10) begin
      errors++;
      $display("FAIL op_count got %0d/%0d exp 10/10", res_cnt_o, res_cnt_o4);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid_i  = 1'b1;
      sel_i    = 3'd0;
      data_i_1 = W'(8'h11 * i);
      data_i_2 = W'(8'hF8 + i);
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got 0 exp 1", i);
      end
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (xfers != 10 || res_cnt_o !== 16'd10 || max_run != 10) begin
      errors++;
      $display("FAIL b2b_stream got xfers=%0d cnt=%0d run=%0d exp 10 10 10", xfers, res_cnt_o, max_run);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    do_reset();
    mon_en  = 1'b1;
    ready_i = 1'b0;
    valid_i = 1'b1;
    sel_i = 3'd0; data_i_1 = 8'h03; data_i_2 = 8'h01;
    repeat (5) begin
      @(negedge clk);
      if (ready_o) acc++;
      @(posedge clk); #1;
      sel_i    = SW'(acc);
      data_i_1 = W'(8'h11 * acc + 3);
      data_i_2 = W'(acc + 1);
    end
    @(negedge clk);
    checks++;
    if (acc != 2 || ready_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got acc=%0d ready_o=%b valid_o=%b exp 2 0 1", acc, ready_o, valid_o);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    for (int k = acc; k < 6; k++) send(3'(k), W'(8'h11 * k + 3), W'(k + 1));
    drain();
    checks++;
    if (xfers != 6 || res_cnt_o !== 16'd6) begin
      errors++;
      $display("FAIL bp_count got %0d/%0d exp 6", xfers, res_cnt_o);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 17; i++) send(3'd5, W'(i), 8'h5A);
    drain();
    checks++;
    if (res_cnt_o4 !== 4'd1 || res_cnt_o !== 16'd17) begin
      errors++;
      $display("FAIL cnt_wrap got %0d/%0d exp 1/17", res_cnt_o4, res_cnt_o);
    end
  endtask

  task automatic test_random();
    int   n = 0;
    int   cyc = 0;
    logic done = 1'b0;
    do_reset();
    mon_en = 1'b1;
    fork
      begin
        while (n < 1000 && cyc < 20000) begin
          valid_i  = ($urandom_range(3) != 0);
          sel_i    = SW'($urandom);
          data_i_1 = W'($urandom);
          data_i_2 = (sel_i == 3'd6) ? W'($urandom_range(20)) : W'($urandom);
          @(negedge clk);
          if (valid_i && ready_o) n++;
          @(posedge clk); #1;
          cyc++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready_i = ($urandom_range(2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    checks++;
    if (n != 1000) begin
      errors++;
      $display("FAIL rand_accept got %0d exp 1000", n);
    end
    drain();
    checks++;
    if (xfers != 1000 || res_cnt_o !== CW'(xfers)) begin
      errors++;
      $display("FAIL rand_count got xfers=%0d cnt=%0d exp 1000 1000", xfers, res_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    mon_en  = 1'b0;
    ready_i = 1'b0;
    send(3'd0, 8'h12, 8'h34);
    send(3'd2, 8'h05, 8'h06);
    valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_inflight got valid_o=%b ready_o=%b exp 1 0", valid_o, ready_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== '0 || res_cnt_o !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b d=%h c=%0d exp 0 0 0", valid_o, data_o, res_cnt_o);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
        errors++;
        $display("FAIL mid_stale%0d got valid_o=%b ready_o=%b exp 0 1", i, valid_o, ready_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_opcodes();
    test_back_to_back();
    test_backpressure();
    test_counter_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
